// File: rtl/fastram_sync_ctrl.sv
// Zorro II autoconfig FastRAM controller: NUM_BLOCKS chained 2MB blocks sharing one
// DRAM array, with synchronous RAS/CAS sequencing and CAS-before-RAS refresh.
module fastram_sync_ctrl #(
  parameter int          NUM_BLOCKS       = 4,
  parameter int          REFRESH_INTERVAL = 100,
  parameter logic [15:0] MFG_ID           = 16'h07DB,
  parameter logic [7:0]  PROD_ID          = 8'd70,
  parameter logic [15:0] SERIAL           = 16'd421
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CFGINn,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        RWn,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DBUS_IN,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  output logic [11:0] MADDR,
  output logic        CFGOUTn,
  output logic        RASn,
  output logic        UCASn,
  output logic        LCASn,
  output logic        OEn,
  output logic        MEMWn,
  output logic        CONFIGURED
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_COL  = 3'd2;
  localparam logic [2:0] S_PRE  = 3'd3;
  localparam logic [2:0] S_RCAS = 3'd4;
  localparam logic [2:0] S_RRAS = 3'd5;

  localparam int          CW       = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);
  localparam logic [1:0]  LAST_IDX = 2'(NUM_BLOCKS - 1);

  logic [1:0]            idx;
  logic [2:0]            base [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic                  shutup;
  logic                  wr_q;
  logic [CW-1:0]         ref_cnt;
  logic [1:0]            pending;
  logic [2:0]            state;
  logic [11:0]           row_q;

  logic       ac_active;
  logic       ac_wr;
  logic       ac_wr_rise;
  logic [7:0] reg_off;
  logic       chain;
  logic [3:0] ac_nib;
  logic       hit;
  logic       expire;
  logic       dec;

  assign ac_active  = (ADDR[23:16] == 8'hE8) & ~CFGINn & ~shutup;
  assign ac_wr      = ac_active & ~ASn & ~RWn & ~UDSn;
  assign ac_wr_rise = ac_wr & ~wr_q;
  assign reg_off    = ADDR[8:1];
  assign chain      = (idx < LAST_IDX);
  assign DBUS_OE    = ac_active & RWn & ~ASn & ~UDSn;
  assign CONFIGURED = |valid;

  always_comb begin
    case (reg_off)
      8'h00:   ac_nib = 4'b1110;
      8'h01:   ac_nib = {chain, 3'b110};
      8'h02:   ac_nib = ~PROD_ID[7:4];
      8'h03:   ac_nib = ~PROD_ID[3:0];
      8'h04:   ac_nib = ~4'b1000;
      8'h08:   ac_nib = ~MFG_ID[15:12];
      8'h09:   ac_nib = ~MFG_ID[11:8];
      8'h0A:   ac_nib = ~MFG_ID[7:4];
      8'h0B:   ac_nib = ~MFG_ID[3:0];
      8'h10:   ac_nib = ~SERIAL[15:12];
      8'h11:   ac_nib = ~SERIAL[11:8];
      8'h12:   ac_nib = ~SERIAL[7:4];
      8'h13:   ac_nib = ~SERIAL[3:0];
      8'h20:   ac_nib = 4'h0;
      8'h21:   ac_nib = 4'h0;
      default: ac_nib = 4'hF;
    endcase
  end

  // Base 0 and base 7 (which covers the E8 autoconfig window) never decode.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      if (valid[k] && (base[k] == ADDR[23:21]) && (base[k] != 3'd0) && (base[k] != 3'd7))
        hit = 1'b1;
    end
    hit = hit & ~ASn;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx      <= 2'd0;
      valid    <= '0;
      shutup   <= 1'b0;
      wr_q     <= 1'b0;
      CFGOUTn  <= 1'b1;
      DBUS_OUT <= 4'hF;
      for (int k = 0; k < NUM_BLOCKS; k++) base[k] <= 3'd0;
    end else begin
      wr_q     <= ac_wr;
      DBUS_OUT <= ac_nib;
      if (ASn) CFGOUTn <= ~shutup;
      if (ac_wr_rise) begin
        if (reg_off == 8'h24 && !DBUS_IN[0]) begin
          base[idx]  <= DBUS_IN[3:1];
          valid[idx] <= 1'b1;
          if (idx == LAST_IDX) shutup <= 1'b1;
          else                 idx    <= idx + 2'd1;
        end else if (reg_off == 8'h26) begin
          shutup <= 1'b1;
        end
      end
    end
  end

  assign expire = (ref_cnt == '0);
  assign dec    = (state == S_RRAS);

  // A refresh request and a completed refresh in the same cycle cancel out.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ref_cnt <= RELOAD;
      pending <= 2'd0;
    end else begin
      ref_cnt <= expire ? RELOAD : ref_cnt - 1'b1;
      if (expire && !dec) begin
        if (pending != 2'd3) pending <= pending + 2'd1;
      end else if (dec && !expire) begin
        pending <= pending - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      row_q <= 12'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            state <= S_ROW;
            row_q <= ADDR[22:11];
          end else if (pending != 2'd0 && ASn) begin
            state <= S_RCAS;
          end
        end
        S_ROW: begin
          if (ASn)                      state <= S_PRE;
          else if (RWn | ~UDSn | ~LDSn) state <= S_COL;
        end
        S_COL:   if (ASn) state <= S_PRE;
        S_PRE:   state <= S_IDLE;
        S_RCAS:  state <= S_RRAS;
        S_RRAS:  state <= S_PRE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so a reset edge releases them immediately.
  always_comb begin
    RASn  = 1'b1;
    UCASn = 1'b1;
    LCASn = 1'b1;
    OEn   = 1'b1;
    MEMWn = 1'b1;
    MADDR = 12'd0;
    case (state)
      S_ROW: begin
        RASn  = 1'b0;
        MADDR = row_q;
      end
      S_COL: begin
        RASn  = 1'b0;
        MADDR = {2'b00, ADDR[10:1]};
        UCASn = UDSn | ASn;
        LCASn = LDSn | ASn;
        OEn   = ASn;
        MEMWn = RWn | ASn;
      end
      S_RCAS: begin
        UCASn = 1'b0;
        LCASn = 1'b0;
      end
      S_RRAS: begin
        RASn  = 1'b0;
        UCASn = 1'b0;
        LCASn = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
